column_tracer: RTL and testbench

- Per-frame column tracer, successor to the fixed 240-column divider tracer.
- Walks columns 0..NUM_COLS-1 and computes a wall height and side flag for each column, using a fixed-latency radix-2 restoring divider.
- Streams each result to the column-height buffer over a valid/ready handshake.
- Runs during VBLANK. Parametrised in column count, widths and numerator; has selectable trace modes and a cycle profiler.

---
 rtl/tracer_pkg.sv | 30 +++
 rtl/restoring_divider.sv | 69 ++++++
 rtl/column_tracer.sv | 176 +++++++++++++++++
 tb/tb_column_tracer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracer_pkg.sv
// Shared encodings and helpers for the column tracer.
package tracer_pkg;

    localparam logic [1:0] MODE_RECIP = 2'd0;
    localparam logic [1:0] MODE_ANIM  = 2'd1;
    localparam logic [1:0] MODE_DEBUG = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDivide,
        StOutput
    } state_e;

    // Clamp a raw height into 1..ceiling; zero means "too far away" and maps to 1.
    function automatic logic [31:0] clamp_height(input logic [31:0] value,
                                                 input logic [31:0] ceiling);
        logic [31:0] result;
        if (value == 32'd0) begin
            result = 32'd1;
        end else if (value > ceiling) begin
            result = ceiling;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/restoring_divider.sv
// Radix-2 restoring divider with a fixed DIV_W-cycle start-to-done latency.
// The first step is taken on the start cycle directly from the input operands.
module restoring_divider #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic [DIV_W-1:0] quotient_o,
    output logic [DIV_W-1:0] remainder_o,
    output logic             done_o
);

    localparam int unsigned CntW = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] rem_q, quo_q, dvs_q;
    logic [CntW-1:0]  cnt_q;
    logic             done_q;

    logic [DIV_W-1:0] src_rem, src_quo, src_dvs;
    logic [DIV_W-1:0] step_rem, step_quo;
    logic [DIV_W:0]   trial, diff;

    // One restoring step, fed from the operands on start or from the working registers.
    always_comb begin
        src_rem  = start_i ? '0 : rem_q;
        src_quo  = start_i ? dividend_i : quo_q;
        src_dvs  = start_i ? divisor_i : dvs_q;
        trial    = {src_rem, src_quo[DIV_W-1]};
        diff     = trial - {1'b0, src_dvs};
        step_rem = trial[DIV_W-1:0];
        step_quo = {src_quo[DIV_W-2:0], 1'b0};
        if (trial >= {1'b0, src_dvs}) begin
            step_rem = diff[DIV_W-1:0];
            step_quo = {src_quo[DIV_W-2:0], 1'b1};
        end
    end

    // Working registers; done pulses the cycle after the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= step_rem;
            quo_q  <= step_quo;
            dvs_q  <= divisor_i;
            cnt_q  <= CntW'(DIV_W - 1);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q  <= step_rem;
            quo_q  <= step_quo;
            cnt_q  <= cnt_q - CntW'(1);
            done_q <= (cnt_q == CntW'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign done_o      = done_q;

endmodule

// File: rtl/column_tracer.sv
// Per-frame column tracer: walks every column, derives a wall height and side
// flag (by division or from a debug constant) and streams them out over valid/ready.
module column_tracer
    import tracer_pkg::*;
#(
    parameter int unsigned NUM_COLS = 640,
    parameter int unsigned COL_W    = 10,
    parameter int unsigned H_W      = 8,
    parameter int unsigned H_MAX    = 240,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned NUMER    = 240,
    parameter int unsigned CYC_W    = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [H_W-1:0]   debug_height_i,
    input  logic [7:0]       debug_frame_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [COL_W-1:0] out_column_o,
    output logic [H_W-1:0]   out_height_o,
    output logic             out_side_o,
    output logic [CYC_W-1:0] cycle_count_o
);

    state_e state_q, state_d;

    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       frame_q, frame_d;
    logic [H_W-1:0]   height_q, height_d;
    logic             side_q, side_d;
    logic             done_q, done_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    logic             div_start, div_done;
    logic [DIV_W-1:0] div_quo, div_rem, divisor;
    logic [COL_W-1:0] anim_col;
    logic             last_col, busy;

    assign last_col = (col_q == COL_W'(NUM_COLS - 1));
    // Animated mode wraps the offset column within the column index space.
    assign anim_col = col_q + COL_W'(frame_q);
    assign divisor  = ((mode_q == MODE_ANIM) ? DIV_W'(anim_col) : DIV_W'(col_q)) + DIV_W'(1);

    restoring_divider #(
        .DIV_W(DIV_W)
    ) u_divider (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .dividend_i (DIV_W'(NUMER)),
        .divisor_i  (divisor),
        .quotient_o (div_quo),
        .remainder_o(div_rem),
        .done_o     (div_done)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; dropping enable aborts from any state.
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (start_i) state_d = StLoad;
                StLoad:   state_d = (mode_q == MODE_DEBUG) ? StOutput : StDivide;
                StDivide: if (div_done) state_d = StOutput;
                StOutput: if (out_ready_i) state_d = last_col ? StIdle : StLoad;
                default:  state_d = StIdle;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        busy        = (state_q != StIdle);
        out_valid_o = (state_q == StOutput);
        div_start   = (state_q == StLoad) && (mode_q != MODE_DEBUG);
    end

    // Datapath next-state: frame latches, column walk, result capture, profiler.
    always_comb begin
        col_d    = col_q;
        mode_d   = mode_q;
        frame_d  = frame_q;
        height_d = height_q;
        side_d   = side_q;
        done_d   = 1'b0;
        cyc_d    = (busy && !(&cyc_q)) ? cyc_q + CYC_W'(1) : cyc_q;
        if (!enable_i) begin
            col_d    = '0;
            height_d = '0;
            side_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mode_d  = mode_i;
                        frame_d = debug_frame_i;
                        col_d   = '0;
                        cyc_d   = '0;
                    end
                end
                StLoad: begin
                    if (mode_q == MODE_DEBUG) begin
                        height_d = H_W'(clamp_height(32'(debug_height_i), 32'(H_MAX)));
                        side_d   = col_q[0];
                    end
                end
                StDivide: begin
                    if (div_done) begin
                        height_d = H_W'(clamp_height(32'(div_quo), 32'(H_MAX)));
                        side_d   = (div_rem == '0);
                    end
                end
                StOutput: begin
                    if (out_ready_i) begin
                        if (last_col) begin
                            col_d    = '0;
                            height_d = '0;
                            side_d   = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; cycle_count is cleared only by reset or a new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q    <= '0;
            mode_q   <= MODE_RECIP;
            frame_q  <= '0;
            height_q <= '0;
            side_q   <= 1'b0;
            done_q   <= 1'b0;
            cyc_q    <= '0;
        end else begin
            col_q    <= col_d;
            mode_q   <= mode_d;
            frame_q  <= frame_d;
            height_q <= height_d;
            side_q   <= side_d;
            done_q   <= done_d;
            cyc_q    <= cyc_d;
        end
    end

    assign busy_o        = busy;
    assign done_o        = done_q;
    assign out_column_o  = col_q;
    assign out_height_o  = height_q;
    assign out_side_o    = side_q;
    assign cycle_count_o = cyc_q;

endmodule

// File: tb/tb_column_tracer.sv
// Scoreboard bench for column_tracer: expected columns are queued at start and
// checked as the tracer hands them over.
module tb_column_tracer;

    localparam int unsigned NumCols = 300;
    localparam int unsigned ColW    = 10;
    localparam int unsigned HW      = 8;
    localparam int unsigned HMax    = 240;
    localparam int unsigned DivW    = 16;
    localparam int unsigned Numer   = 240;
    localparam int unsigned CycW    = 20;

    typedef struct {
        int col;
        int height;
        int side;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [HW-1:0]   debug_height = '0;
    logic [7:0]      debug_frame = '0;
    logic            busy, done, out_valid, out_side;
    logic            out_ready = 1'b1;
    logic [ColW-1:0] out_column;
    logic [HW-1:0]   out_height;
    logic [CycW-1:0] cycle_count;

    int cyc = 0;
    int last_accept_cyc = 0;
    int stall_col = -1;
    int stall_left = 0;
    int cap_h[NumCols];
    int cap_s[NumCols];

    column_tracer #(
        .NUM_COLS(NumCols),
        .COL_W   (ColW),
        .H_W     (HW),
        .H_MAX   (HMax),
        .DIV_W   (DivW),
        .NUMER   (Numer),
        .CYC_W   (CycW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable),
        .start_i       (start),
        .mode_i        (mode),
        .debug_height_i(debug_height),
        .debug_frame_i (debug_frame),
        .busy_o        (busy),
        .done_o        (done),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_column_o  (out_column),
        .out_height_o  (out_height),
        .out_side_o    (out_side),
        .cycle_count_o (cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int md, input int frm, input int dh, input int col);
        exp_t e;
        int   dv, q, r;
        e.col = col;
        if (md == 2) begin
            e.height = (dh == 0) ? 1 : (dh > int'(HMax)) ? int'(HMax) : dh;
            e.side   = col % 2;
        end else begin
            dv = ((md == 1) ? ((col + frm) % (1 << ColW)) : col) + 1;
            q  = int'(Numer) / dv;
            r  = int'(Numer) % dv;
            e.height = (q == 0) ? 1 : (q > int'(HMax)) ? int'(HMax) : q;
            e.side   = (r == 0) ? 1 : 0;
        end
        return e;
    endfunction

    // Backpressure driver: holds out_ready low while the chosen column is offered.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && out_valid === 1'b1 && int'(out_column) == stall_col) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard pops on handshake, stability check while stalled.
    initial begin
        exp_t e;
        logic            hold_v = 1'b0;
        logic [ColW-1:0] hold_c;
        logic [HW-1:0]   hold_h;
        logic            hold_s;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (hold_v) begin
                    check_eq("hold_column", out_column, hold_c);
                    check_eq("hold_height", out_height, hold_h);
                    check_eq("hold_side", out_side, hold_s);
                end
                if (out_ready) begin
                    hold_v = 1'b0;
                    if (sb_q.size() == 0) begin
                        check_eq("sb_pending", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("column", out_column, e.col);
                        check_eq("height", out_height, e.height);
                        check_eq("side", out_side, e.side);
                        cap_h[out_column] = int'(out_height);
                        cap_s[out_column] = int'(out_side);
                    end
                    last_accept_cyc = cyc;
                end else begin
                    hold_v = 1'b1;
                    hold_c = out_column;
                    hold_h = out_height;
                    hold_s = out_side;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic pulse_start(input int md, input int frm, input int dh);
        @(posedge clk);
        #1;
        mode         = 2'(md);
        debug_frame  = 8'(frm);
        debug_height = HW'(dh);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Runs one frame to completion; optionally pulses a stray start mid-frame.
    task automatic run_frame(input int md, input int frm, input int dh, input int exp_cyc,
                             input int stray_at);
        int got_done = 0;
        int done_cyc = 0;
        for (int c = 0; c < int'(NumCols); c++) begin
            cap_h[c] = -1;
            cap_s[c] = -1;
            sb_q.push_back(model(md, frm, dh, c));
        end
        pulse_start(md, frm, dh);
        for (int i = 0; i < int'(NumCols) * 20 + 100; i++) begin
            @(negedge clk);
            if (i == stray_at) begin
                mode  = 2'd2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got_done = 1;
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        check_eq("done_seen", got_done, 1);
        check_eq("done_latency", done_cyc - last_accept_cyc, 1);
        check_eq("sb_drained", sb_q.size(), 0);
        check_eq("cycle_count", cycle_count, exp_cyc);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_valid", out_valid, 0);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
        sb_q.delete();
    endtask

    initial begin
        int done_cnt;
        int found;
        int heights[8] = '{240, 120, 80, 60, 48, 40, 34, 30};
        int sides[8]   = '{1, 1, 1, 1, 1, 1, 0, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_column", out_column, 0);
        check_eq("rst_height", out_height, 0);
        check_eq("rst_side", out_side, 0);
        check_eq("rst_cycles", cycle_count, 0);
        reset = 1'b0;

        // start with enable low is ignored
        pulse_start(0, 0, 0);
        @(negedge clk);
        check_eq("start_disabled", busy, 0);
        enable = 1'b1;

        // mode 0 with a stray start (and mode change) mid-frame
        run_frame(0, 0, 0, NumCols * (DivW + 2), 100);
        for (int c = 0; c < 8; c++) begin
            check_eq($sformatf("m0_h%0d", c), cap_h[c], heights[c]);
            check_eq($sformatf("m0_s%0d", c), cap_s[c], sides[c]);
        end
        check_eq("m0_h239", cap_h[239], 1);
        check_eq("m0_s239", cap_s[239], 1);
        check_eq("m0_h240", cap_h[240], 1);
        check_eq("m0_s240", cap_s[240], 0);

        // mode 1 animation offset
        run_frame(1, 3, 0, NumCols * (DivW + 2), -1);
        check_eq("m1_h0", cap_h[0], 60);
        check_eq("m1_s0", cap_s[0], 1);

        // mode 2 low clamp
        run_frame(2, 0, 0, NumCols * 2, -1);
        check_eq("m2_h0", cap_h[0], 1);
        check_eq("m2_s0", cap_s[0], 0);
        check_eq("m2_s1", cap_s[1], 1);

        // mode 2 high clamp with backpressure on column 2
        stall_col  = 2;
        stall_left = 5;
        run_frame(2, 0, 250, NumCols * 2 + 5, -1);
        check_eq("m2_h5", cap_h[5], 240);
        check_eq("stall_used", stall_left, 0);
        stall_col = -1;

        // abort during column 4 divide
        for (int c = 0; c < int'(NumCols); c++) sb_q.push_back(model(0, 0, 0, c));
        pulse_start(0, 0, 0);
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (int'(out_column) == 4 && busy === 1'b1 && out_valid === 1'b0) begin
                found = 1;
                break;
            end
        end
        check_eq("abort_reached_col4", found, 1);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_column", out_column, 0);
        check_eq("abort_popped", int'(NumCols) - sb_q.size(), 4);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check_eq("abort_no_done", done_cnt, 0);
        sb_q.delete();
        enable = 1'b1;

        // fresh frame after abort restarts at column 0
        run_frame(2, 0, 100, NumCols * 2, -1);
        check_eq("restart_h0", cap_h[0], 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
